// File: rtl/verilab_gpio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | verilab_gpio_pkg                                                   |
// | Register map indices and controller FSM state type for the GPIO.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package verilab_gpio_pkg;

  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_EN       = 3'd1;
  localparam logic [2:0] GPIO_IN       = 3'd2;
  localparam logic [2:0] GPIO_RISE_EN  = 3'd3;
  localparam logic [2:0] GPIO_FALL_EN  = 3'd4;
  localparam logic [2:0] GPIO_IRQ_MASK = 3'd5;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } gpio_state_t;

endpackage
`default_nettype wire

// File: rtl/verilab_sync_bit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | verilab_sync_bit                                                   |
// | Single-bit N-flop synchroniser for asynchronous pad inputs.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module verilab_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ff <= '0;
    end else begin
      r_ff <= {r_ff[STAGES-2:0], d};
    end
  end

  assign q = r_ff[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/verilab_gpio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | verilab_gpio_ctrl                                                  |
// | Core-side GPIO controller: pad drive, input edge IRQ, reg port.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module verilab_gpio_ctrl
  import verilab_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             irq,
  input  logic [WIDTH-1:0] core_gpio_in,
  output logic [WIDTH-1:0] core_gpio_out,
  output logic [WIDTH-1:0] core_gpio_en
);

  gpio_state_t      r_state;
  gpio_state_t      w_state_nxt;
  logic             w_accept;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_en;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_irq_stat;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rdata;
  logic             r_irq;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rmux;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sync
      verilab_sync_bit #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (core_gpio_in[gi]),
        .q       (w_sync[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Requests arriving while in ACK are dropped; only IDLE accepts.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_wr = w_accept & we;
  assign w_rd = w_accept & ~we;

  always_comb begin
    w_rmux = '0;
    case (addr)
      GPIO_OUT:      w_rmux = r_out;
      GPIO_EN:       w_rmux = r_en;
      GPIO_IN:       w_rmux = w_sync;
      GPIO_RISE_EN:  w_rmux = r_rise_en;
      GPIO_FALL_EN:  w_rmux = r_fall_en;
      GPIO_IRQ_MASK: w_rmux = r_irq_mask;
      GPIO_IRQ_STAT: w_rmux = r_irq_stat;
      default:       w_rmux = '0;
    endcase
  end

  assign w_w1c  = (w_wr && (addr == GPIO_IRQ_STAT)) ? wdata : '0;
  assign w_rise = w_sync & ~r_prev & r_rise_en;
  assign w_fall = ~w_sync & r_prev & r_fall_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out      <= '0;
      r_en       <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_mask <= '0;
      r_irq_stat <= '0;
      r_prev     <= '0;
      r_rdata    <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr) begin
        case (addr)
          GPIO_OUT:      r_out      <= wdata;
          GPIO_EN:       r_en       <= wdata;
          GPIO_RISE_EN:  r_rise_en  <= wdata;
          GPIO_FALL_EN:  r_fall_en  <= wdata;
          GPIO_IRQ_MASK: r_irq_mask <= wdata;
          default:       ;
        endcase
      end
      // New edges are ORed in after the clear, so a set beats a same-cycle W1C.
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_rise | w_fall;
      r_prev     <= w_sync;
      r_rdata    <= w_rd ? w_rmux : '0;
      r_irq      <= |(r_irq_stat & r_irq_mask);
    end
  end

  assign ready         = (r_state == ST_ACK);
  assign rdata         = r_rdata;
  assign irq           = r_irq;
  assign core_gpio_out = r_out;
  assign core_gpio_en  = r_en;

endmodule
`default_nettype wire

// File: tb/tb_verilab_gpio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_verilab_gpio_ctrl                                               |
// | Directed scenarios plus randomized traffic against a history model.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_verilab_gpio_ctrl;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk;
  logic         reset_n;
  logic         req;
  logic         we;
  logic [2:0]   addr;
  logic [W-1:0] wdata;
  logic [W-1:0] pad_in;
  logic         ready;
  logic [W-1:0] rdata;
  logic         irq;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_en;

  int checks   = 0;
  int failures = 0;

  verilab_gpio_ctrl #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .ready         (ready),
    .rdata         (rdata),
    .irq           (irq),
    .core_gpio_in  (pad_in),
    .core_gpio_out (gpio_out),
    .core_gpio_en  (gpio_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pad history array stands in for the synchroniser,
  // hist[k] being the pad value seen k+1 clocks ago.
  logic [W-1:0] m_out, m_en, m_rise_en, m_fall_en, m_mask, m_stat, m_rdata;
  logic         m_irq, m_busy;
  logic [W-1:0] hist [0:S];
  logic [W-1:0] m_sync, m_prev, m_rd_val, m_w1c, m_rise, m_fall;
  logic         m_accept;

  always_comb begin
    m_sync   = hist[S-1];
    m_prev   = hist[S];
    m_accept = req && !m_busy;
    m_rise   = m_sync & ~m_prev & m_rise_en;
    m_fall   = ~m_sync & m_prev & m_fall_en;
    m_w1c    = (m_accept && we && addr == 3'd6) ? wdata : '0;
    m_rd_val = '0;
    case (addr)
      3'd0: m_rd_val = m_out;
      3'd1: m_rd_val = m_en;
      3'd2: m_rd_val = m_sync;
      3'd3: m_rd_val = m_rise_en;
      3'd4: m_rd_val = m_fall_en;
      3'd5: m_rd_val = m_mask;
      3'd6: m_rd_val = m_stat;
      default: m_rd_val = '0;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out <= '0; m_en <= '0; m_rise_en <= '0; m_fall_en <= '0;
      m_mask <= '0; m_stat <= '0; m_rdata <= '0; m_irq <= 1'b0; m_busy <= 1'b0;
      for (int i = 0; i <= S; i++) hist[i] <= '0;
    end else begin
      m_irq   <= |(m_stat & m_mask);
      m_stat  <= (m_stat & ~m_w1c) | m_rise | m_fall;
      m_busy  <= m_accept;
      m_rdata <= (m_accept && !we) ? m_rd_val : '0;
      if (m_accept && we) begin
        case (addr)
          3'd0: m_out     <= wdata;
          3'd1: m_en      <= wdata;
          3'd3: m_rise_en <= wdata;
          3'd4: m_fall_en <= wdata;
          3'd5: m_mask    <= wdata;
          default: ;
        endcase
      end
      hist[0] <= pad_in;
      for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
    end
  end

  task automatic access(input logic w, input logic [2:0] a, input logic [W-1:0] d,
                        output logic rdy, output logic [W-1:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    rdy = ready; rd = rdata;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic read_all_zero(input string tag);
    logic rdy;
    logic [W-1:0] rd;
    for (int a = 0; a < 8; a++) begin
      access(1'b0, 3'(a), '0, rdy, rd);
      checks++;
      if (rdy !== 1'b1 || rd !== '0) begin
        failures++;
        $display("FAIL %s reg%0d: ready=%b rdata=%h, required ready=1 rdata=0", tag, a, rdy, rd);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cycles(3);
    checks++;
    if ({ready, irq} !== 2'b00 || rdata !== '0 || gpio_out !== '0 || gpio_en !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b irq=%b rdata=%h out=%h en=%h, required all 0",
               ready, irq, rdata, gpio_out, gpio_en);
    end
    reset_n = 1'b1;
    read_all_zero("reset_read");
  endtask

  task automatic test_write_readback();
    logic rdy;
    logic [W-1:0] rd;
    access(1'b1, 3'd0, 32'hA5A5_0F0F, rdy, rd);
    checks++;
    if (rdy !== 1'b1 || gpio_out !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL wr_out_pad: ready=%b out=%h, required ready=1 out=a5a50f0f", rdy, gpio_out);
    end
    access(1'b1, 3'd1, 32'hFFFF_0000, rdy, rd);
    checks++;
    if (rdy !== 1'b1 || gpio_en !== 32'hFFFF_0000) begin
      failures++;
      $display("FAIL wr_en_pad: ready=%b en=%h, required ready=1 en=ffff0000", rdy, gpio_en);
    end
    access(1'b0, 3'd0, '0, rdy, rd);
    checks++;
    if (rdy !== 1'b1 || rd !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL rd_out: ready=%b rdata=%h, required ready=1 rdata=a5a50f0f", rdy, rd);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rdata !== '0) begin
      failures++;
      $display("FAIL ready_one_cycle: ready=%b rdata=%h, required ready=0 rdata=0", ready, rdata);
    end
    access(1'b1, 3'd7, 32'hDEAD_BEEF, rdy, rd);
    access(1'b0, 3'd7, '0, rdy, rd);
    checks++;
    if (rdy !== 1'b1 || rd !== '0) begin
      failures++;
      $display("FAIL rd_reserved: ready=%b rdata=%h, required ready=1 rdata=0", rdy, rd);
    end
  endtask

  task automatic test_rise_irq();
    logic rdy;
    logic [W-1:0] rd;
    access(1'b1, 3'd3, 32'h1, rdy, rd);
    access(1'b1, 3'd5, 32'h1, rdy, rd);
    @(negedge clk);
    pad_in[0] = 1'b1;
    wait_cycles(2);
    // Read sampled on the edge that sets the bit sees the old value.
    req = 1'b1; we = 1'b0; addr = 3'd6;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (ready !== 1'b1 || rdata !== '0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rise_latency3: ready=%b stat=%h irq=%b, required ready=1 stat=0 irq=0",
               ready, rdata, irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL rise_irq4: irq=%b, required 1", irq);
    end
    access(1'b0, 3'd6, '0, rdy, rd);
    checks++;
    if (rd !== 32'h1) begin
      failures++;
      $display("FAIL rise_stat: stat=%h, required 00000001", rd);
    end
  endtask

  task automatic test_w1c();
    logic rdy;
    logic [W-1:0] rd;
    access(1'b1, 3'd6, 32'h1, rdy, rd);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL w1c_irq_drop: irq=%b, required 0", irq);
    end
    pad_in[0] = 1'b0;
    wait_cycles(5);
    access(1'b0, 3'd6, '0, rdy, rd);
    checks++;
    if (rd !== '0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL fall_no_rise_en: stat=%h irq=%b, required stat=0 irq=0", rd, irq);
    end
    @(negedge clk);
    pad_in[0] = 1'b1;
    wait_cycles(2);
    req = 1'b1; we = 1'b1; addr = 3'd6; wdata = 32'h1;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    access(1'b0, 3'd6, '0, rdy, rd);
    checks++;
    if (rd !== 32'h1 || irq !== 1'b1) begin
      failures++;
      $display("FAIL w1c_collision: stat=%h irq=%b, required stat=00000001 irq=1", rd, irq);
    end
    access(1'b1, 3'd6, 32'h1, rdy, rd);
    wait_cycles(2);
  endtask

  task automatic test_mask();
    logic rdy;
    logic [W-1:0] rd;
    access(1'b1, 3'd5, 32'h0, rdy, rd);
    access(1'b1, 3'd4, 32'h8000_0000, rdy, rd);
    pad_in[31] = 1'b1;
    wait_cycles(4);
    pad_in[31] = 1'b0;
    wait_cycles(5);
    access(1'b0, 3'd6, '0, rdy, rd);
    checks++;
    if (rd !== 32'h8000_0000 || irq !== 1'b0) begin
      failures++;
      $display("FAIL mask_fall31: stat=%h irq=%b, required stat=80000000 irq=0", rd, irq);
    end
    access(1'b1, 3'd5, 32'h8000_0000, rdy, rd);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL unmask_irq: irq=%b, required 1", irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    pat = '0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[5-i] = ready;
      if (ready === 1'b1) begin
        checks++;
        if (rdata !== 32'hA5A5_0F0F) begin
          failures++;
          $display("FAIL b2b_rdata: rdata=%h, required a5a50f0f", rdata);
        end
      end
    end
    req = 1'b0;
    checks++;
    if (pat !== 6'b101010) begin
      failures++;
      $display("FAIL b2b_pattern: ready=%b, required 101010", pat);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (ready !== m_busy || rdata !== m_rdata || irq !== m_irq ||
          gpio_out !== m_out || gpio_en !== m_en) begin
        failures++;
        $display("FAIL rand_cyc%0d: ready=%b rdata=%h irq=%b out=%h en=%h, required %b %h %b %h %h",
                 c, ready, rdata, irq, gpio_out, gpio_en, m_busy, m_rdata, m_irq, m_out, m_en);
      end
      req   = ($urandom_range(0, 2) != 0);
      we    = 1'($urandom_range(0, 1));
      addr  = 3'($urandom_range(0, 7));
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) pad_in = pad_in ^ $urandom;
    end
    req = 1'b0; we = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset_midstream();
    logic rdy;
    logic [W-1:0] rd;
    pad_in = '0;
    access(1'b1, 3'd0, 32'h1234_5678, rdy, rd);
    access(1'b1, 3'd3, '1, rdy, rd);
    access(1'b1, 3'd5, '1, rdy, rd);
    wait_cycles(4);
    pad_in = '1;
    wait_cycles(5);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_irq: irq=%b, required 1", irq);
    end
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 3'd1; wdata = '1;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || irq !== 1'b0 || gpio_en !== '0 || gpio_out !== '0 || rdata !== '0) begin
      failures++;
      $display("FAIL async_reset: ready=%b irq=%b en=%h out=%h rdata=%h, required all 0",
               ready, irq, gpio_en, gpio_out, rdata);
    end
    pad_in = '0;
    wait_cycles(3);
    reset_n = 1'b1;
    read_all_zero("midreset_read");
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pad_in = '0; reset_n = 1'b0;
    test_reset();
    test_write_readback();
    test_rise_irq();
    test_w1c();
    test_mask();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
